// File: rtl/dcmi_capture_ctrl.sv
// Purpose: DCMI capture sequencer that arms on request, aligns to frames, decimates, crops and writes pixels.
// Latency: one clock from an accepted pixel to pix_wr/pix_wdata; event pulses are registered one clock after their cause.
// Backpressure: none towards the sensor; a kept pixel that meets fifo_full is dropped and reported on ovr_err.
// Ports: clk/rstn; capture_req, snapshot_mode, fcrc and crop_* are configuration; vsync_act/hsync_act/pix_vld/pix_data
//   form the decoded video stream; fifo_full is FIFO status; pix_wr/pix_wdata drive the FIFO; capture_en,
//   frame_start, frame_end, line_end, ovr_err and frame_cnt report status to the interrupt block.
module dcmi_capture_ctrl #(
  parameter int DW  = 14,
  parameter int CW  = 14,
  parameter int FCW = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           capture_req,
  input  logic           snapshot_mode,
  input  logic [1:0]     fcrc,
  input  logic           crop_en,
  input  logic [CW-1:0]  crop_hstart,
  input  logic [CW-1:0]  crop_vstart,
  input  logic [CW-1:0]  crop_hsize,
  input  logic [CW-1:0]  crop_vsize,
  input  logic           vsync_act,
  input  logic           hsync_act,
  input  logic           pix_vld,
  input  logic [DW-1:0]  pix_data,
  input  logic           fifo_full,
  output logic           pix_wr,
  output logic [DW-1:0]  pix_wdata,
  output logic           capture_en,
  output logic           frame_start,
  output logic           frame_end,
  output logic           line_end,
  output logic           ovr_err,
  output logic [FCW-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_FS, SKIP, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic          vsync_d, hsync_d;
  logic          snap_l, snap_done;
  logic [1:0]    fcrc_l, fsel_cnt, fsel_mask;
  logic          crop_en_l;
  logic [CW-1:0] hstart_l, vstart_l, hsize_l, vsize_l;
  logic [CW-1:0] hcnt, vcnt;

  logic vs_rise, vs_fall, hs_fall;
  logic arm, start, fsel_inc, snap_set;
  logic frame_start_nxt, frame_end_nxt, line_end_nxt;
  logic h_in, v_in, in_win, v_ok, keep;

  // Window ends are computed one bit wider so start+size never wraps.
  logic [CW:0] h_end, v_end;

  assign vs_rise = vsync_act & ~vsync_d;
  assign vs_fall = ~vsync_act & vsync_d;
  assign hs_fall = ~hsync_act & hsync_d;

  assign h_end  = {1'b0, hstart_l} + {1'b0, hsize_l};
  assign v_end  = {1'b0, vstart_l} + {1'b0, vsize_l};
  assign h_in   = ({1'b0, hcnt} >= {1'b0, hstart_l}) && ({1'b0, hcnt} < h_end);
  assign v_in   = ({1'b0, vcnt} >= {1'b0, vstart_l}) && ({1'b0, vcnt} < v_end);
  assign in_win = ~crop_en_l | (h_in & v_in);
  assign v_ok   = ~crop_en_l | v_in;
  assign keep   = (state == CAPTURE) & pix_vld & vsync_act & hsync_act & in_win;

  always_comb begin
    state_nxt       = state;
    arm             = 1'b0;
    start           = 1'b0;
    fsel_inc        = 1'b0;
    snap_set        = 1'b0;
    frame_start_nxt = 1'b0;
    frame_end_nxt   = 1'b0;
    line_end_nxt    = 1'b0;
    case (fcrc_l)
      2'b01:   fsel_mask = 2'b01;
      2'b10:   fsel_mask = 2'b11;
      default: fsel_mask = 2'b00;
    endcase
    case (state)
      IDLE: begin
        // After a snapshot the request level must drop before re-arming,
        // otherwise a held request would grab a second frame.
        if (capture_req && !snap_done) begin
          state_nxt = WAIT_FS;
          arm       = 1'b1;
        end
      end
      WAIT_FS: begin
        if (!capture_req) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          fsel_inc = 1'b1;
          if ((fsel_cnt & fsel_mask) == 2'b00) begin
            state_nxt       = CAPTURE;
            start           = 1'b1;
            frame_start_nxt = 1'b1;
          end else begin
            state_nxt = SKIP;
          end
        end
      end
      SKIP: begin
        if (vs_fall) state_nxt = capture_req ? WAIT_FS : IDLE;
      end
      CAPTURE: begin
        line_end_nxt = hs_fall & v_ok;
        if (vs_fall) begin
          frame_end_nxt = 1'b1;
          if (snap_l || !capture_req) begin
            state_nxt = IDLE;
            snap_set  = snap_l;
          end else begin
            state_nxt = WAIT_FS;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      vsync_d     <= 1'b0;
      hsync_d     <= 1'b0;
      snap_l      <= 1'b0;
      snap_done   <= 1'b0;
      fcrc_l      <= '0;
      fsel_cnt    <= '0;
      crop_en_l   <= 1'b0;
      hstart_l    <= '0;
      vstart_l    <= '0;
      hsize_l     <= '0;
      vsize_l     <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      capture_en  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_end    <= 1'b0;
      ovr_err     <= 1'b0;
      pix_wr      <= 1'b0;
      pix_wdata   <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      vsync_d     <= vsync_act;
      hsync_d     <= hsync_act;
      capture_en  <= (state_nxt != IDLE);
      snap_done   <= capture_req & (snap_done | snap_set);
      frame_start <= frame_start_nxt;
      frame_end   <= frame_end_nxt;
      line_end    <= line_end_nxt;
      pix_wr      <= keep & ~fifo_full;
      ovr_err     <= keep & fifo_full;
      if (keep && !fifo_full) pix_wdata <= pix_data;
      if (frame_end_nxt) frame_cnt <= frame_cnt + FCW'(1);
      if (arm) begin
        snap_l   <= snapshot_mode;
        fcrc_l   <= fcrc;
        fsel_cnt <= '0;
      end else if (fsel_inc) begin
        fsel_cnt <= fsel_cnt + 2'd1;
      end
      if (start) begin
        crop_en_l <= crop_en;
        hstart_l  <= crop_hstart;
        vstart_l  <= crop_vstart;
        hsize_l   <= crop_hsize;
        vsize_l   <= crop_vsize;
        hcnt      <= '0;
        vcnt      <= '0;
      end else if (state == CAPTURE) begin
        if (hs_fall) begin
          hcnt <= '0;
          if (vcnt != '1) vcnt <= vcnt + CW'(1);
        end else if (pix_vld && hsync_act && hcnt != '1) begin
          hcnt <= hcnt + CW'(1);
        end
      end
    end
  end

endmodule
